// File: rtl/ram_sdp_be.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read/write collision behaviour and a hardware clear sequencer.
module ram_sdp_be #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                RD_LAT     = 1,
    parameter int                WR_FIRST   = 0,
    parameter logic [DATA_W-1:0] CLR_VAL    = '0,
    parameter int                CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_start,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic              rd_ok;

    logic [DATA_W-1:0] mem [DEPTH];

    assign busy  = (state == CLEAR);
    assign rd_ok = (state == IDLE) && rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_start) state_next = CLEAR;
            CLEAR:   if (clr_cnt == {ADDR_W{1'b1}}) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The single write port is shared between the clear sequencer and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_be    = wr_be;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = !rst;
            mem_addr  = clr_cnt;
            mem_be    = '1;
            mem_wdata = CLR_VAL;
        end else begin
            mem_we    = wr_en && !rst;
        end
    end

    // NOTE: the array has no reset; clearing is done by the sequencer so the RAM still maps to block memory.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Array read returns the pre-write word; write-first overlays the enabled incoming bytes.
    always_comb begin
        rd_word = mem[rd_addr];
        if ((WR_FIRST != 0) && (state == IDLE) && wr_en && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s1_data;
            logic              s1_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    s1_valid <= rd_ok;
                    if (rd_ok) s1_data <= rd_word;
                    rd_valid <= s1_valid;
                    if (s1_valid) rd_data <= s1_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) rd_data <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances share stimulus (A: read-first, 1-cycle, clear on reset;
// B: write-first, 2-cycle, no clear on reset) and are checked against a reference model and scoreboard.
module tb_ram_sdp_be;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] CLRV_A = 32'h5EED_F00D;
    localparam logic [31:0] CLRV_B = 32'h0BAD_CAFE;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        wr_en, rd_en, clr_start;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    ram_sdp_be #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1), .WR_FIRST(0), .CLR_VAL(CLRV_A), .CLR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .clr_start(clr_start), .busy(busy_a));

    ram_sdp_be #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2), .WR_FIRST(1), .CLR_VAL(CLRV_B), .CLR_ON_RST(0)) u_b (
        .clk(clk), .rst(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .clr_start(clr_start), .busy(busy_b));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // Reference model state per instance (index 0 = A, 1 = B).
    logic [31:0] mdl [2][DEPTH];
    bit          active [2];
    int          ptr [2];
    int          rst_due [2] = '{-1, -1};
    logic [31:0] last [2]    = '{32'h0, 32'h0};
    int          lat_p [2]   = '{1, 2};
    bit          wrf_p [2]   = '{1'b0, 1'b1};
    bit          cor_p [2]   = '{1'b1, 1'b0};
    logic [31:0] clrv_p [2]  = '{CLRV_A, CLRV_B};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // Reset discards reads whose result would land after the reset edge.
    task automatic flush(input int d);
        if (d == 0) begin
            while (q_a.size() > 0 && q_a[$].due > cyc) void'(q_a.pop_back());
        end else begin
            while (q_b.size() > 0 && q_b[$].due > cyc) void'(q_b.pop_back());
        end
    endtask

    task automatic check_busy(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] wa, input logic [3:0] be, input logic [31:0] wd,
                         input logic re, input logic [7:0] ra, input logic cs, input logic ra_r, input logic rb_r);
        logic        r [2];
        exp_t        e;
        logic [31:0] w;
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra; clr_start = cs;
        rst_a = ra_r; rst_b = rb_r;
        r[0] = ra_r; r[1] = rb_r;
        for (int d = 0; d < 2; d++) begin
            if (r[d]) begin
                flush(d);
                rst_due[d] = cyc + 1;
                active[d]  = cor_p[d];
                ptr[d]     = 0;
            end else if (active[d]) begin
                mdl[d][ptr[d]] = clrv_p[d];
                ptr[d]++;
                if (ptr[d] == DEPTH) begin
                    active[d] = 1'b0;
                    ptr[d]    = 0;
                end
            end else begin
                if (re) begin
                    w = mdl[d][ra];
                    if (we && wa == ra && wrf_p[d]) w = merge(w, wd, be);
                    e.data = w;
                    e.due  = cyc + lat_p[d];
                    push(d, e);
                end
                if (we) mdl[d][wa] = merge(mdl[d][wa], wd, be);
                if (cs) begin
                    active[d] = 1'b1;
                    ptr[d]    = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_busy("busy_a", busy_a, active[0]);
        check_busy("busy_b", busy_b, active[1]);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
        drive(1'b1, a, be, d, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, a, 1'b0, 1'b0, 1'b0);
    endtask

    // Every negedge: a due result must appear; otherwise rd_valid is low and rd_data holds.
    task automatic mon(input int d, input logic v, input logic [31:0] dat);
        exp_t  e;
        bit    due = 1'b0;
        string tag = (d == 0) ? "rd_a" : "rd_b";
        if (d == 0) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin due = 1'b1; e = q_a.pop_front(); end
        end else begin
            if (q_b.size() > 0 && q_b[0].due == cyc) begin due = 1'b1; e = q_b.pop_front(); end
        end
        checks++;
        if (due) begin
            assert (v === 1'b1 && dat === e.data) else begin
                failures++;
                $error("FAIL %s: valid=%b data=%h expected valid=1 data=%h cyc=%0d", tag, v, dat, e.data, cyc);
            end
            last[d] = e.data;
        end else if (cyc == rst_due[d]) begin
            assert (v === 1'b0 && dat === 32'h0) else begin
                failures++;
                $error("FAIL %s_reset: valid=%b data=%h expected valid=0 data=0 cyc=%0d", tag, v, dat, cyc);
            end
            last[d] = 32'h0;
        end else begin
            assert (v === 1'b0 && dat === last[d]) else begin
                failures++;
                $error("FAIL %s_hold: valid=%b data=%h expected valid=0 data=%h cyc=%0d", tag, v, dat, last[d], cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon(0, rd_valid_a, rd_data_a);
            mon(1, rd_valid_b, rd_data_b);
        end
    end

    initial begin
        // Reset: A enters its clear, B stays idle and is cleared by clr_start.
        repeat (2) drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0);
        idle(258);
        rd(8'd0);
        rd(8'd128);
        rd(8'd255);
        idle(2);

        // Byte enables, including an all-disabled write.
        wr(8'h10, 4'hF, 32'hAABBCCDD);
        wr(8'h10, 4'b0101, 32'h11223344);
        rd(8'h10);
        wr(8'h10, 4'h0, 32'hFFFFFFFF);
        rd(8'h10);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) wr(8'(i), 4'hF, 32'(i + 5));
        for (int i = 0; i < 4; i++) rd(8'(i));
        idle(2);

        // Same-address collisions, full and partial enables.
        wr(8'h20, 4'hF, 32'h0);
        drive(1'b1, 8'h20, 4'hF, 32'h5A, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        rd(8'h20);
        drive(1'b1, 8'h20, 4'b0110, 32'h11223344, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        rd(8'h20);
        idle(2);

        // clr_start with a read in the same cycle, then traffic ignored while busy.
        wr(8'h03, 4'hF, 32'h77);
        drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h03, 4'hF, 32'hFFFF_0000 + 32'(i), 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        idle(250);
        rd(8'h03);
        idle(2);

        // Reset at clear cycle 100: A restarts its clear, B aborts leaving a partial clear.
        wr(8'd200, 4'hF, 32'h12345678);
        wr(8'd50,  4'hF, 32'h9ABCDEF0);
        drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, (i == 50), 1'b0, 1'b0);
        drive(1'b0, 8'h0, 4'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b1);
        rd(8'd200);
        rd(8'd50);
        idle(254);
        rd(8'd200);
        rd(8'd50);
        idle(4);

        checks++;
        assert (q_a.size() == 0 && q_b.size() == 0) else begin
            failures++;
            $error("FAIL drain: pending_a=%0d pending_b=%0d expected 0", q_a.size(), q_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
